// File: rtl/tremolo_pkg.sv
// Shared definitions for the multi-channel tremolo effect.
//
// Contents:
//   wave_e    - LFO waveform select (triangle, square, falling saw, reserved)
//   RATE_INC  - per-accepted-sample phase increment for each i_rate code
//   GAIN_ONE  - unity gain in Q1.16
//   lfo_value - maps the top 17 phase bits to a 16-bit unsigned LFO level
package tremolo_pkg;

    typedef enum logic [1:0] {
        TRI = 2'd0,
        SQR = 2'd1,
        SAW = 2'd2,
        RSV = 2'd3
    } wave_e;

    // Roughly 1, 2, 3, 4, 6, 8, 12 and 20 Hz at 48 kHz with a 24-bit accumulator.
    localparam int unsigned RATE_INC [8] = '{350, 700, 1049, 1398, 2097, 2796, 4194, 6991};

    localparam logic [16:0] GAIN_ONE = 17'd65536;

    // ph is the phase MSB followed by the next 16 bits.
    function automatic logic [15:0] lfo_value(input wave_e wave, input logic [16:0] ph);
        logic [15:0] lvl;
        case (wave)
            SQR:     lvl = ph[16] ? 16'hFFFF : 16'h0000;
            SAW:     lvl = ~ph[16:1];
            // Reserved code falls back to triangle.
            default: lvl = ph[16] ? ~ph[15:0] : ph[15:0];
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/tremolo_lfo_gain.sv
// LFO-to-gain conversion for one tremolo channel (purely combinational).
//
// Ports:
//   phase_top - top 17 bits of the channel phase (MSB first)
//   wave      - waveform select
//   depth     - modulation depth, 0 = none, 255 = ~full
//   gain      - Q1.16 unsigned gain, 257..65536
import tremolo_pkg::*;

module tremolo_lfo_gain (
    input  logic [16:0] phase_top,
    input  wave_e       wave,
    input  logic [7:0]  depth,
    output logic [16:0] gain
);

    logic [15:0] lfo;
    logic [15:0] lfo_inv;
    logic [23:0] atten_full;
    logic [15:0] atten;

    assign lfo        = lfo_value(wave, phase_top);
    // 65535 - L is just the bitwise complement for a 16-bit value.
    assign lfo_inv    = ~lfo;
    assign atten_full = {8'd0, lfo_inv} * {16'd0, depth};
    // Largest attenuation is 65535*255 >> 8 = 65279, so gain never drops below 257.
    assign atten      = 16'(atten_full >> 8);
    assign gain       = GAIN_ONE - {1'b0, atten};

endmodule

// File: rtl/effect_tremolo_mc.sv
// Multi-channel tremolo (amplitude modulation) with an internal phase-accumulator LFO.
//
// The LFO advances once per accepted enabled frame. Each frame passes through a fixed
// two-stage pipeline: stage 1 captures samples and per-channel gain, stage 2 applies
// the gain with round-half-up and drives the outputs. Disabled mode uses the same
// pipeline with unity gain, so bypass latency matches active latency.
//
// Build option: define TREMOLO_STEREO_PHASE_EN to give channel c the phase offset
// c * 2^PHASE_W / CH (spread / auto-pan tremolo, one gain datapath per channel).
// Without it all channels share a single gain computed from the base phase.
//
// Ports:
//   i_clk     - system clock
//   i_rst_n   - asynchronous active-low reset
//   i_valid   - one-cycle strobe, i_data holds a new frame
//   i_enable  - 1 = tremolo active, 0 = bypass and hold LFO at its start phase
//   i_rate    - LFO rate select (index into RATE_INC)
//   i_wave    - 0 triangle, 1 square, 2 falling saw, 3 triangle
//   i_depth   - modulation depth
//   i_data    - CH packed signed samples, channel 0 in the LSBs
//   o_data    - CH packed processed samples, held between strobes
//   o_valid   - i_valid delayed by exactly two cycles
import tremolo_pkg::*;

module effect_tremolo_mc #(
    parameter int DATA_W  = 16,
    parameter int CH      = 2,
    parameter int PHASE_W = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic                 i_enable,
    input  logic [2:0]           i_rate,
    input  logic [1:0]           i_wave,
    input  logic [7:0]           i_depth,
    input  logic [CH*DATA_W-1:0] i_data,
    output logic [CH*DATA_W-1:0] o_data,
    output logic                 o_valid
);

    localparam logic [PHASE_W-1:0] PHASE_START = {1'b1, {(PHASE_W-1){1'b0}}};
    localparam int                 PROD_W      = DATA_W + 18;
    localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(32768);

    // Gain is at most 1.0, so the rounded result always fits DATA_W bits.
    function automatic logic signed [DATA_W-1:0] scale_round(
        input logic signed [DATA_W-1:0] x,
        input logic [16:0]              g
    );
        logic signed [PROD_W-1:0] prod;
        prod = $signed({{18{x[DATA_W-1]}}, x}) * $signed({{(DATA_W+1){1'b0}}, g});
        prod = prod + ROUND_HALF;
        return DATA_W'(prod >>> 16);
    endfunction

    logic [PHASE_W-1:0] phase;
    wave_e              wave_sel;
    logic [16:0]        gain [CH];

    assign wave_sel = wave_e'(i_wave);

    // The gain for a frame is derived from the phase before this frame advances it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase <= PHASE_START;
        end else if (!i_enable) begin
            phase <= PHASE_START;
        end else if (i_valid) begin
            phase <= phase + PHASE_W'(RATE_INC[i_rate]);
        end
    end

`ifdef TREMOLO_STEREO_PHASE_EN
    for (genvar c = 0; c < CH; c++) begin : g_lfo
        logic [PHASE_W-1:0] phase_c;
        assign phase_c = phase + PHASE_W'(64'(c) * ((64'd1 << PHASE_W) / 64'(CH)));
        tremolo_lfo_gain u_lfo_gain (
            .phase_top (phase_c[PHASE_W-1 -: 17]),
            .wave      (wave_sel),
            .depth     (i_depth),
            .gain      (gain[c])
        );
    end
`else
    logic [16:0] gain_shared;
    tremolo_lfo_gain u_lfo_gain (
        .phase_top (phase[PHASE_W-1 -: 17]),
        .wave      (wave_sel),
        .depth     (i_depth),
        .gain      (gain_shared)
    );
    for (genvar c = 0; c < CH; c++) begin : g_gain_fanout
        assign gain[c] = gain_shared;
    end
`endif

    // ---- Stage 1: capture samples and gain ----
    logic signed [DATA_W-1:0] x_p1    [CH];
    logic [16:0]              gain_p1 [CH];
    logic                     vld_p1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1 <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                x_p1[c]    <= '0;
                gain_p1[c] <= '0;
            end
        end else begin
            vld_p1 <= i_valid;
            if (i_valid) begin
                for (int c = 0; c < CH; c++) begin
                    x_p1[c]    <= i_data[c*DATA_W +: DATA_W];
                    gain_p1[c] <= i_enable ? gain[c] : GAIN_ONE;
                end
            end
        end
    end

    // ---- Stage 2: multiply, round, register outputs ----
    logic [CH*DATA_W-1:0] data_p2;
    logic                 vld_p2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_p2 <= '0;
            vld_p2  <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                for (int c = 0; c < CH; c++) begin
                    data_p2[c*DATA_W +: DATA_W] <= scale_round(x_p1[c], gain_p1[c]);
                end
            end
        end
    end

    assign o_data  = data_p2;
    assign o_valid = vld_p2;

endmodule

// File: tb/tb_effect_tremolo_mc.sv
module tb_effect_tremolo_mc;

    localparam int DATA_W  = 16;
    localparam int CH      = 2;
    localparam int PHASE_W = 24;

`ifdef TREMOLO_STEREO_PHASE_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 valid;
    logic                 enable;
    logic [2:0]           rate;
    logic [1:0]           wave;
    logic [7:0]           depth;
    logic [CH*DATA_W-1:0] din;
    logic [CH*DATA_W-1:0] dout;
    logic                 ovalid;

    always #5 clk = ~clk;

    effect_tremolo_mc #(
        .DATA_W  (DATA_W),
        .CH      (CH),
        .PHASE_W (PHASE_W)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (valid),
        .i_enable (enable),
        .i_rate   (rate),
        .i_wave   (wave),
        .i_depth  (depth),
        .i_data   (din),
        .o_data   (dout),
        .o_valid  (ovalid)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [1:0]  wave;
        logic [7:0]  depth;
        logic [15:0] x0;
        logic [15:0] x1;
        logic [15:0] y0;
        logic [15:0] y1;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic [1:0] w, input logic [7:0] d,
                                input logic [15:0] x0, input logic [15:0] x1,
                                input logic [15:0] y0, input logic [15:0] y1);
        vec_t v;
        v.en = en; v.wave = w; v.depth = d;
        v.x0 = x0; v.x1 = x1; v.y0 = y0; v.y1 = y1;
        return v;
    endfunction

    // Scoreboard for streamed frames
    logic [31:0] exp_q [$];
    logic [31:0] exp_word;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && ovalid) begin
            if (exp_q.size() == 0) begin
                chk("stream_unexpected_valid", {31'd0, ovalid}, 32'd0);
            end else begin
                exp_word = exp_q.pop_front();
                chk("stream_data", dout, exp_word);
            end
        end
    end

    // One isolated frame starting from the LFO start phase, with latency and hold checks.
    task automatic apply_vec(input vec_t v, input int idx);
        @(posedge clk); #1;
        enable = 1'b0; valid = 1'b0;
        @(posedge clk); #1;
        enable = v.en; wave = v.wave; depth = v.depth; rate = 3'd3;
        din = {v.x1, v.x0}; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        chk($sformatf("vec%0d_valid_t1", idx), {31'd0, ovalid}, 32'd0);
        @(posedge clk); #1;
        chk($sformatf("vec%0d_valid_t2", idx), {31'd0, ovalid}, 32'd1);
        chk($sformatf("vec%0d_data", idx), dout, {v.y1, v.y0});
        @(posedge clk); #1;
        chk($sformatf("vec%0d_valid_t3", idx), {31'd0, ovalid}, 32'd0);
        chk($sformatf("vec%0d_hold", idx), dout, {v.y1, v.y0});
    endtask

    task automatic stream_frame(input logic [1:0] w, input logic [2:0] r, input logic [7:0] d,
                                input logic [31:0] x, input logic [31:0] y);
        @(posedge clk); #1;
        enable = 1'b1; wave = w; rate = r; depth = d; din = x; valid = 1'b1;
        exp_q.push_back(y);
    endtask

    task automatic idle_cycle(input logic en);
        @(posedge clk); #1;
        enable = en; valid = 1'b0;
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = mk(1'b0, 2'd0, 8'd255, 16'h1234, 16'h8000, 16'h1234, 16'h8000);
        tbl[1] = mk(1'b1, 2'd0, 8'd255, 16'd16384, 16'd16384, 16'd16384,
                    STEREO ? 16'd64 : 16'd16384);
        tbl[2] = mk(1'b1, 2'd1, 8'd255, 16'h8000, 16'd12345, 16'h8000,
                    STEREO ? 16'd48 : 16'd12345);
        tbl[3] = mk(1'b1, 2'd0, 8'd128, 16'd1000, -16'sd1000, 16'd1000,
                    STEREO ? -16'sd500 : -16'sd1000);
        tbl[4] = mk(1'b1, 2'd3, 8'd255, 16'd20000, -16'sd20000, 16'd20000,
                    STEREO ? -16'sd78 : -16'sd20000);
        tbl[5] = mk(1'b1, 2'd0, 8'd0, 16'd32767, 16'h8000, 16'd32767, 16'h8000);

        rst_n = 1'b0; valid = 1'b0; enable = 1'b0; rate = '0; wave = '0; depth = '0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, ovalid}, 32'd0);
        chk("reset_data", dout, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) apply_vec(tbl[i], i);

        // Depth 0: random back-to-back frames must pass through bit-exactly.
        idle_cycle(1'b0);
        mon_en = 1'b1;
        for (int i = 0; i < 500; i++) begin
            logic [31:0] x;
            x = $urandom;
            stream_frame(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'd0, x, x);
        end
        idle_cycle(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("depth0_drain", exp_q.size(), 32'd0);

        // Square, fastest rate, full depth: unity until the phase wraps at frame 1200.
        idle_cycle(1'b0);
        for (int n = 0; n <= 1200; n++) begin
            logic [15:0] y0;
            logic [15:0] y1;
            y0 = (n < 1200) ? 16'd16384 : 16'd64;
            y1 = STEREO ? ((n < 1200) ? 16'd64 : 16'd16384) : y0;
            stream_frame(2'd1, 3'd7, 8'd255, {16'd16384, 16'd16384}, {y1, y0});
        end
        // Phase is now in its low half: square with depth 128 gives G=32769.
        stream_frame(2'd1, 3'd7, 8'd128, {16'h8000, 16'h8000},
                     {STEREO ? 16'h8000 : 16'hC000, 16'hC000});
        idle_cycle(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("square_drain", exp_q.size(), 32'd0);

        // Enable dropped for one cycle with a frame in stage 1: that frame keeps its gain,
        // the next enabled frame restarts at unity.
        idle_cycle(1'b0);
        stream_frame(2'd0, 3'd7, 8'd255, {16'd16384, 16'd16384},
                     {STEREO ? 16'd64 : 16'd16384, 16'd16384});
        stream_frame(2'd0, 3'd7, 8'd255, {16'd16384, 16'd16384},
                     {STEREO ? 16'd78 : 16'd16371, 16'd16371});
        idle_cycle(1'b0);
        stream_frame(2'd0, 3'd7, 8'd255, {16'd16384, 16'd16384},
                     {STEREO ? 16'd64 : 16'd16384, 16'd16384});
        idle_cycle(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("toggle_drain", exp_q.size(), 32'd0);
        mon_en = 1'b0;

        // Reset with two frames in flight: neither may emerge.
        @(posedge clk); #1;
        enable = 1'b1; wave = 2'd0; depth = 8'd0; din = 32'h1111_2222; valid = 1'b1;
        @(posedge clk); #1;
        din = 32'h3333_4444;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'd0, ovalid}, 32'd0);
        chk("rst_async_data", dout, 32'd0);
        valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_hold_valid", {31'd0, ovalid}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_after_valid", {31'd0, ovalid}, 32'd0);
            chk("rst_after_data", dout, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
